// File: rtl/alu_serial_ctrl_if.sv
// Request/response bus between the CPU slow-path sequencer and alu_serial_ctrl.
// Optional build macro: ALU_SERIAL_ABORT_EN adds the 'abort' request line.
interface alu_serial_ctrl_if #(
    parameter int unsigned WIDTH = 64
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] opA;
    logic [WIDTH-1:0] opB;
`ifdef ALU_SERIAL_ABORT_EN
    logic             abort;
`endif
    logic             ready;
    logic             done;
    logic             err;
    logic [WIDTH-1:0] result;
    logic             negative;
    logic             zero;
    logic             overflow;
    logic             carryOut;

    // Requester side: issues operations, consumes result and flags.
    modport master (
`ifdef ALU_SERIAL_ABORT_EN
        output abort,
`endif
        output start, op, opA, opB,
        input  ready, done, err, result, negative, zero, overflow, carryOut
    );

    // Controller side.
    modport slave (
`ifdef ALU_SERIAL_ABORT_EN
        input  abort,
`endif
        input  start, op, opA, opB,
        output ready, done, err, result, negative, zero, overflow, carryOut
    );
endinterface

// File: rtl/alu_serial_ctrl.sv
// Bit-serial initiator for a single alu1 slice. Operands are shifted out
// LSB-first, the ripple carry lives in one flop, and the result is assembled
// in a shadow shift register that becomes visible only on entry to DONE.
// Optional build macro: ALU_SERIAL_ABORT_EN (abort input on the bus, RUN only).
module alu_serial_ctrl #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    alu_serial_ctrl_if.slave bus,
    output logic             sliceA,
    output logic             sliceB,
    output logic             sliceCin,
    output logic [2:0]       sliceCtrl,
    input  logic             sliceOut,
    input  logic             sliceP,
    input  logic             sliceG
);
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [2:0] OP_PASS_B = 3'b000;
    localparam logic [2:0] OP_ADD    = 3'b010;
    localparam logic [2:0] OP_SUB    = 3'b011;
    localparam logic [2:0] OP_AND    = 3'b100;
    localparam logic [2:0] OP_OR     = 3'b101;
    localparam logic [2:0] OP_XOR    = 3'b110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } stateT;

    stateT            state, stateNext;
    logic [WIDTH-1:0] aShift, bShift, shadow, shadowNext;
    logic [2:0]       opReg;
    logic [CW-1:0]    cnt;
    logic             carry, carryNext;
    logic             legalOp, isArith;
    logic             accept, lastBit, abortNow;

    assign legalOp = (bus.op == OP_PASS_B) || (bus.op == OP_ADD) || (bus.op == OP_SUB) ||
                     (bus.op == OP_AND) || (bus.op == OP_OR) || (bus.op == OP_XOR);
    assign isArith    = (opReg == OP_ADD) || (opReg == OP_SUB);
    assign carryNext  = sliceG | (sliceP & carry);
    assign shadowNext = {sliceOut, shadow[WIDTH-1:1]};

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state decode plus handshake and slice drive.
    always_comb begin
        stateNext = state;
        bus.ready = 1'b0;
        bus.done  = 1'b0;
        sliceA    = 1'b0;
        sliceB    = 1'b0;
        sliceCin  = 1'b0;
        sliceCtrl = '0;
        accept    = 1'b0;
        lastBit   = 1'b0;
        abortNow  = 1'b0;
        case (state)
            IDLE: begin
                bus.ready = 1'b1;
                if (bus.start && legalOp) begin
                    accept    = 1'b1;
                    stateNext = RUN;
                end
            end
            RUN: begin
                sliceA    = aShift[0];
                sliceB    = bShift[0];
                sliceCin  = carry;
                sliceCtrl = opReg;
                lastBit   = (cnt == CW'(WIDTH - 1));
`ifdef ALU_SERIAL_ABORT_EN
                abortNow  = bus.abort;
`endif
                if (abortNow) begin
                    stateNext = IDLE;
                end else if (lastBit) begin
                    stateNext = DONE;
                end
            end
            DONE: begin
                bus.done  = 1'b1;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // Operand/carry/result datapath; result and flags update only on the final bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            aShift       <= '0;
            bShift       <= '0;
            shadow       <= '0;
            opReg        <= '0;
            cnt          <= '0;
            carry        <= 1'b0;
            bus.err      <= 1'b0;
            bus.result   <= '0;
            bus.negative <= 1'b0;
            bus.zero     <= 1'b0;
            bus.overflow <= 1'b0;
            bus.carryOut <= 1'b0;
        end else begin
            bus.err <= (state == IDLE) && bus.start && !legalOp;
            if (accept) begin
                aShift <= bus.opA;
                bShift <= bus.opB;
                opReg  <= bus.op;
                cnt    <= '0;
                carry  <= (bus.op == OP_SUB);
            end else if (state == RUN && !abortNow) begin
                aShift <= aShift >> 1;
                bShift <= bShift >> 1;
                shadow <= shadowNext;
                carry  <= carryNext;
                cnt    <= cnt + 1'b1;
                if (lastBit) begin
                    // carry here is the carry into the MSB, carryNext the carry out.
                    bus.result   <= shadowNext;
                    bus.negative <= sliceOut;
                    bus.zero     <= (shadowNext == '0);
                    bus.carryOut <= isArith & carryNext;
                    bus.overflow <= isArith & (carry ^ carryNext);
                end
            end
        end
    end
endmodule
